array_host_ctrl: RTL and testbench

//  Host-side sequencer for the systolic-array top level: the initiator that drives

---
 rtl/array_host_ctrl.sv | 152 +++++++++++++++
 tb/tb_array_host_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/array_host_ctrl.sv
// Host-side sequencer for the systolic array: collect operands, burst-load the input SRAM,
// start, wait out the compute time, burst-read results and stream them out. Optional macro: ARRAY_HOST_CTRL_PERF_EN.
module array_host_ctrl #(
  parameter int DEPTH          = 8,
  parameter int DATA_W         = 32,
  parameter int OUT_W          = 64,
  parameter int COMPUTE_CYCLES = 16,
  parameter int RD_LAT         = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] input_sram_in,
  output logic              write_input,
  output logic              start,
  output logic              read_output,
  input  logic [OUT_W-1:0]  ram_out
`ifdef ARRAY_HOST_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(DEPTH + RD_LAT + COMPUTE_CYCLES) + 1;

  localparam logic [2:0] S_COLLECT = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_READ    = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;

  logic [2:0]        r_state;
  logic [CW-1:0]     r_cnt;   // word index for COLLECT / LOAD / DRAIN
  logic [TW-1:0]     r_tcnt;  // cycle count for WAIT / READ
  logic              r_done;
  logic [DATA_W-1:0] r_ibuf [DEPTH];
  logic [OUT_W-1:0]  r_obuf [DEPTH];

  logic              w_s_hs;
  logic              w_m_hs;
  logic [AW-1:0]     w_oidx;

  assign w_s_hs = s_valid && (r_state == S_COLLECT);
  assign w_m_hs = m_ready && (r_state == S_DRAIN);
  assign w_oidx = AW'(r_tcnt - TW'(RD_LAT));

  // Strobes decode straight from state so an async reset drops them immediately.
  assign s_ready       = (r_state == S_COLLECT);
  assign busy          = (r_state != S_COLLECT);
  assign write_input   = (r_state == S_LOAD);
  assign start         = (r_state == S_START);
  assign read_output   = (r_state == S_READ);
  assign m_valid       = (r_state == S_DRAIN);
  assign input_sram_in = write_input ? r_ibuf[r_cnt[AW-1:0]] : '0;
  assign m_data        = m_valid ? r_obuf[r_cnt[AW-1:0]] : '0;
  assign done          = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_COLLECT: if (w_s_hs) begin
          if (r_cnt == CW'(DEPTH - 1)) begin
            r_cnt   <= '0;
            r_state <= S_LOAD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          if (r_cnt == CW'(DEPTH - 1)) begin
            r_cnt   <= '0;
            r_state <= S_START;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_START: begin
          r_tcnt  <= '0;
          r_state <= (COMPUTE_CYCLES > 1) ? S_WAIT : S_READ;
        end
        // Start cycle plus COMPUTE_CYCLES-1 wait cycles puts the first read at start+COMPUTE_CYCLES.
        S_WAIT: begin
          if (r_tcnt == TW'(COMPUTE_CYCLES - 2)) begin
            r_tcnt  <= '0;
            r_state <= S_READ;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_READ: begin
          if (r_tcnt == TW'(DEPTH + RD_LAT - 1)) begin
            r_tcnt  <= '0;
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_DRAIN: if (w_m_hs) begin
          if (r_cnt == CW'(DEPTH - 1)) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= S_COLLECT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  // Data buffers carry no reset; their contents are only observed after being written.
  always_ff @(posedge clk) begin
    if (w_s_hs)
      r_ibuf[r_cnt[AW-1:0]] <= s_data;
    if (r_state == S_READ && r_tcnt >= TW'(RD_LAT))
      r_obuf[w_oidx] <= ram_out;
  end

`ifdef ARRAY_HOST_CTRL_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_perf <= '0;
    else if (r_state == S_START)
      r_perf <= 32'd1;
    else if ((r_state == S_WAIT || r_state == S_READ || r_state == S_DRAIN) && r_perf != 32'hFFFF_FFFF)
      r_perf <= r_perf + 32'd1;
  end

  assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_array_host_ctrl.sv
// Directed bench for array_host_ctrl: models the array top's read path and checks
// LOAD/START/READ timing, result ordering, backpressure and mid-operation reset.
module tb_array_host_ctrl;

  localparam int DEPTH  = 8;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        done;
  logic [31:0] input_sram_in;
  logic        write_input;
  logic        start;
  logic        read_output;
  logic [63:0] ram_out;
`ifdef ARRAY_HOST_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  array_host_ctrl dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done),
    .input_sram_in(input_sram_in), .write_input(write_input),
    .start(start), .read_output(read_output), .ram_out(ram_out)
`ifdef ARRAY_HOST_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Array-top read model: word k appears on ram_out RD_LAT cycles into the read burst.
  int          cyc = 0;
  int          rd_k;
  logic [63:0] ram_base;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge rst)
    if (rst) rd_k <= 0;
    else if (read_output) rd_k <= rd_k + 1;
    else rd_k <= 0;
  assign ram_out = (read_output && rd_k >= RD_LAT) ? ram_base + 64'(rd_k - RD_LAT) : 64'h0;

  logic [31:0] wi_q[$];
  logic [63:0] out_q[$];
  int wi_bursts, start_cnt, ro_len, done_cnt, t_start, t_read, t_last_wi;
  logic        prev_wi = 1'b0, prev_ro = 1'b0, prev_mv = 1'b0, prev_mr = 1'b0;
  logic [63:0] prev_md = '0;

  always @(negedge clk) begin
    if (write_input) begin
      wi_q.push_back(input_sram_in);
      if (!prev_wi) wi_bursts++;
      t_last_wi = cyc;
    end
    if (start) begin start_cnt++; t_start = cyc; end
    if (read_output) begin
      if (!prev_ro) t_read = cyc;
      ro_len++;
    end
    if (done) done_cnt++;
    if (prev_mv && !prev_mr) begin
      check("stall_valid", 64'(m_valid), 64'd1);
      check("stall_data", m_data, prev_md);
    end
    if (m_valid && m_ready) out_q.push_back(m_data);
    check("sready_vs_busy", 64'(s_ready), 64'(!busy));
    prev_wi = write_input; prev_ro = read_output;
    prev_mv = m_valid; prev_mr = m_ready; prev_md = m_data;
  end

  logic [31:0] exp_in [DEPTH];

  task automatic clear_stats();
    wi_q.delete(); out_q.delete();
    wi_bursts = 0; start_cnt = 0; ro_len = 0; done_cnt = 0;
    t_start = 0; t_read = 0; t_last_wi = 0;
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d;
    @(negedge clk);
    while (!s_ready && n < 300) begin n++; @(negedge clk); end
    if (!s_ready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic feed(input logic [31:0] base, input logic [31:0] step, input bit gapped);
    for (int i = 0; i < DEPTH; i++) begin
      exp_in[i] = base + step * i;
      send(exp_in[i]);
      if (gapped) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run_drain(input bit toggle);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 1000) begin
      @(posedge clk); #1;
      m_ready = toggle ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
      n++;
    end
    if (done_cnt == 0) check("done_timeout", 64'd0, 64'd1);
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_batch();
    check("wi_bursts", 64'(wi_bursts), 64'd1);
    check("wi_len", 64'(wi_q.size()), 64'(DEPTH));
    for (int k = 0; k < DEPTH && k < wi_q.size(); k++)
      check($sformatf("wi_data%0d", k), 64'(wi_q[k]), 64'(exp_in[k]));
    check("start_cnt", 64'(start_cnt), 64'd1);
    check("start_after_load", 64'(t_start - t_last_wi), 64'd1);
    check("read_delay", 64'(t_read - t_start), 64'd16);
    check("read_len", 64'(ro_len), 64'(DEPTH + RD_LAT));
    check("out_len", 64'(out_q.size()), 64'(DEPTH));
    for (int k = 0; k < DEPTH && k < out_q.size(); k++)
      check($sformatf("out%0d", k), out_q[k], ram_base + 64'(k));
    check("done_cnt", 64'(done_cnt), 64'd1);
    check("idle_sready", 64'(s_ready), 64'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; ram_base = 64'hA0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sready", 64'(s_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_strobes", {60'd0, write_input, start, read_output, m_valid}, 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mdata", m_data, 64'd0);
`ifdef ARRAY_HOST_CTRL_PERF_EN
    check("rst_perf", 64'(perf_cycles), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // back-to-back operands, sink always ready
    clear_stats();
    feed(32'h01020304, 32'h01010101, 1'b0);
    run_drain(1'b0);
    check_batch();
`ifdef ARRAY_HOST_CTRL_PERF_EN
    check("perf_batch", 64'(perf_cycles), 64'd34);
    repeat (4) @(posedge clk);
    #1;
    check("perf_hold", 64'(perf_cycles), 64'd34);
`endif

    // gapped operands, stalling sink
    clear_stats();
    ram_base = 64'hFEED_0000_0000_1000;
    feed(32'hDEAD_0000, 32'h0000_0011, 1'b1);
    run_drain(1'b1);
    check_batch();

    // reset mid READ burst
    clear_stats();
    feed(32'h3000_0000, 32'd1, 1'b0);
    n = 0;
    @(negedge clk);
    while (!(read_output && rd_k == 4) && n < 500) begin n++; @(negedge clk); end
    check("reach_read4", 64'(read_output && rd_k == 4), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_read", 64'(read_output), 64'd0);
    check("midrst_mvalid", 64'(m_valid), 64'd0);
    check("midrst_sready", 64'(s_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // fresh batch after the aborted one
    clear_stats();
    ram_base = 64'hC0;
    feed(32'h4000_0000, 32'd3, 1'b0);
    run_drain(1'b0);
    check_batch();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
